// File: rtl/adsr_poly_pkg.sv
// rtl/adsr_poly_pkg.sv - shared encodings for the polyphonic ADSR engine
package adsr_poly_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_t;

  typedef enum logic {
    SW_IDLE = 1'b0,
    SW_RUN  = 1'b1
  } sweep_state_t;

  localparam logic [2:0] CFG_SEL_A    = 3'd0;
  localparam logic [2:0] CFG_SEL_D    = 3'd1;
  localparam logic [2:0] CFG_SEL_S    = 3'd2;
  localparam logic [2:0] CFG_SEL_R    = 3'd3;
  localparam logic [2:0] CFG_SEL_MODE = 3'd4;

  localparam logic MODE_HARD   = 1'b0;
  localparam logic MODE_LEGATO = 1'b1;

endpackage

// File: rtl/adsr_poly_voice_step.sv
// rtl/adsr_poly_voice_step.sv - one combinational envelope step for a single voice
module adsr_poly_voice_step
  import adsr_poly_pkg::*;
#(
  parameter int W = 32
) (
  input  env_state_t     state,
  input  logic [W-1:0]   level,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   d,
  input  logic [W-1:0]   s,
  input  logic [W-1:0]   r,
  input  logic           mode,
  input  logic           gate,
  input  logic           prev_gate,
  output env_state_t     next_state,
  output logic [W-1:0]   next_level
);

  localparam logic [W:0] MAX_EXT = {1'b0, {W{1'b1}}};

  logic         rise;
  logic [W:0]   attack_sum;
  logic [W-1:0] retrig_level;
  logic         decay_done;

  assign rise         = gate & ~prev_gate;
  assign attack_sum   = {1'b0, level} + {1'b0, a};
  assign retrig_level = (mode == MODE_LEGATO) ? level : '0;
  // L-D<=S rewritten as L-S<=D so nothing can underflow
  assign decay_done   = (d == '0) || (level <= s) || ((level - s) <= d);

  always_comb begin
    next_state = state;
    next_level = level;
    if (rise) begin
      next_state = ST_ATTACK;
      next_level = retrig_level;
    end else begin
      case (state)
        ST_IDLE: begin
          next_level = '0;
        end
        ST_ATTACK: begin
          if (!gate) begin
            next_state = ST_RELEASE;
          end else if ((a == '0) || (attack_sum >= MAX_EXT)) begin
            next_state = ST_DECAY;
            next_level = '1;
          end else begin
            next_level = attack_sum[W-1:0];
          end
        end
        ST_DECAY: begin
          if (!gate) begin
            next_state = ST_RELEASE;
          end else if (decay_done) begin
            next_state = ST_SUSTAIN;
            next_level = s;
          end else begin
            next_level = level - d;
          end
        end
        ST_SUSTAIN: begin
          if (!gate) begin
            next_state = ST_RELEASE;
          end else begin
            next_level = s;
          end
        end
        ST_RELEASE: begin
          if (gate) begin
            next_state = ST_ATTACK;
            next_level = retrig_level;
          end else if ((r == '0) || (level <= r)) begin
            next_state = ST_IDLE;
            next_level = '0;
          end else begin
            next_level = level - r;
          end
        end
        default: begin
          next_state = ST_IDLE;
          next_level = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/adsr_poly.sv
// rtl/adsr_poly.sv - time-multiplexed polyphonic ADSR envelope generator
// One step engine sweeps all voices per tick and streams levels to the VCA.
module adsr_poly
  import adsr_poly_pkg::*;
#(
  parameter  int W      = 32,
  parameter  int VOICES = 8,
  localparam int VW     = $clog2(VOICES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [VOICES-1:0] gate,
  input  logic              cfg_we,
  input  logic [VW-1:0]     cfg_voice,
  input  logic [2:0]        cfg_sel,
  input  logic [W-1:0]      cfg_data,
  output logic [W-1:0]      env_out,
  output logic [VW-1:0]     env_voice,
  output logic              env_valid,
  output logic              busy,
  output logic              overrun,
  output logic [VOICES-1:0] idle_mask
);

  sweep_state_t      sw_state;
  sweep_state_t      sw_next;
  logic [VW-1:0]     slot;
  logic              last_slot;
  logic              start;
  logic              step_en;

  env_state_t        voice_state [VOICES];
  logic [W-1:0]      voice_level [VOICES];
  logic [W-1:0]      rate_a      [VOICES];
  logic [W-1:0]      rate_d      [VOICES];
  logic [W-1:0]      sus_level   [VOICES];
  logic [W-1:0]      rate_r      [VOICES];
  logic [VOICES-1:0] mode;
  logic [VOICES-1:0] prev_gate;

  env_state_t        step_state;
  logic [W-1:0]      step_level;

  assign last_slot = (slot == VW'(VOICES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_state <= SW_IDLE;
    end else begin
      sw_state <= sw_next;
    end
  end

  always_comb begin
    sw_next = sw_state;
    case (sw_state)
      SW_IDLE: if (tick) sw_next = SW_RUN;
      SW_RUN:  if (last_slot) sw_next = SW_IDLE;
      default: sw_next = SW_IDLE;
    endcase
  end

  // A tick landing mid-sweep is dropped and flagged in the same cycle
  always_comb begin
    busy    = (sw_state == SW_RUN);
    step_en = busy;
    start   = (sw_state == SW_IDLE) && tick;
    overrun = busy && tick;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (start) begin
      slot <= '0;
    end else if (step_en) begin
      slot <= slot + VW'(1);
    end
  end

  adsr_poly_voice_step #(
    .W (W)
  ) u_step (
    .state      (voice_state[slot]),
    .level      (voice_level[slot]),
    .a          (rate_a[slot]),
    .d          (rate_d[slot]),
    .s          (sus_level[slot]),
    .r          (rate_r[slot]),
    .mode       (mode[slot]),
    .gate       (gate[slot]),
    .prev_gate  (prev_gate[slot]),
    .next_state (step_state),
    .next_level (step_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < VOICES; v++) begin
        voice_state[v] <= ST_IDLE;
        voice_level[v] <= '0;
      end
      prev_gate <= '0;
      idle_mask <= '1;
    end else if (step_en) begin
      voice_state[slot] <= step_state;
      voice_level[slot] <= step_level;
      prev_gate[slot]   <= gate[slot];
      idle_mask[slot]   <= (step_state == ST_IDLE);
    end
  end

  // Config registers are independent of the step path, so a write in a slot's
  // own cycle is seen only from the next sweep on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < VOICES; v++) begin
        rate_a[v]    <= '0;
        rate_d[v]    <= '0;
        sus_level[v] <= '0;
        rate_r[v]    <= '0;
      end
      mode <= '0;
    end else if (cfg_we && (int'(cfg_voice) < VOICES)) begin
      case (cfg_sel)
        CFG_SEL_A:    rate_a[cfg_voice]    <= cfg_data;
        CFG_SEL_D:    rate_d[cfg_voice]    <= cfg_data;
        CFG_SEL_S:    sus_level[cfg_voice] <= cfg_data;
        CFG_SEL_R:    rate_r[cfg_voice]    <= cfg_data;
        CFG_SEL_MODE: mode[cfg_voice]      <= cfg_data[0];
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_out   <= '0;
      env_voice <= '0;
      env_valid <= 1'b0;
    end else begin
      env_valid <= step_en;
      if (step_en) begin
        env_out   <= step_level;
        env_voice <= slot;
      end
    end
  end

endmodule

// File: tb/tb_adsr_poly.sv
// tb/tb_adsr_poly.sv - randomized self-checking bench for adsr_poly
// Expected levels come from a per-voice arithmetic model of the envelope rules.
module tb_adsr_poly;

  localparam int W  = 32;
  localparam int NV = 4;
  localparam longint MAXV = 64'h0000_0000_FFFF_FFFF;

  localparam int P_IDLE = 0;
  localparam int P_ATT  = 1;
  localparam int P_DEC  = 2;
  localparam int P_SUS  = 3;
  localparam int P_REL  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic [NV-1:0] gate = '0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_voice = '0;
  logic [2:0]    cfg_sel = '0;
  logic [W-1:0]  cfg_data = '0;
  logic [W-1:0]  env_out;
  logic [1:0]    env_voice;
  logic          env_valid;
  logic          busy;
  logic          overrun;
  logic [NV-1:0] idle_mask;

  int n_tests = 0;
  int n_fail  = 0;

  int     m_phase [NV];
  longint m_lv    [NV];
  longint m_a     [NV];
  longint m_d     [NV];
  longint m_s     [NV];
  longint m_r     [NV];
  bit     m_leg   [NV];
  bit     m_prev  [NV];

  adsr_poly #(.W(W), .VOICES(NV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .gate      (gate),
    .cfg_we    (cfg_we),
    .cfg_voice (cfg_voice),
    .cfg_sel   (cfg_sel),
    .cfg_data  (cfg_data),
    .env_out   (env_out),
    .env_voice (env_voice),
    .env_valid (env_valid),
    .busy      (busy),
    .overrun   (overrun),
    .idle_mask (idle_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int v = 0; v < NV; v++) begin
      m_phase[v] = P_IDLE; m_lv[v] = 0;
      m_a[v] = 0; m_d[v] = 0; m_s[v] = 0; m_r[v] = 0;
      m_leg[v] = 0; m_prev[v] = 0;
    end
  endfunction

  function automatic void model_cfg(input int v, input logic [2:0] sel, input logic [31:0] data);
    case (sel)
      3'd0: m_a[v] = longint'(data);
      3'd1: m_d[v] = longint'(data);
      3'd2: m_s[v] = longint'(data);
      3'd3: m_r[v] = longint'(data);
      3'd4: m_leg[v] = data[0];
      default: ;
    endcase
  endfunction

  function automatic void model_step(input int v, input bit g);
    bit rise;
    rise = g && !m_prev[v];
    m_prev[v] = g;
    if (rise || (m_phase[v] == P_REL && g)) begin
      m_phase[v] = P_ATT;
      if (!m_leg[v]) m_lv[v] = 0;
    end else if (m_phase[v] == P_IDLE) begin
      m_lv[v] = 0;
    end else if (!g) begin
      if (m_phase[v] != P_REL) m_phase[v] = P_REL;
      else if (m_r[v] == 0 || m_lv[v] <= m_r[v]) begin m_lv[v] = 0; m_phase[v] = P_IDLE; end
      else m_lv[v] = m_lv[v] - m_r[v];
    end else if (m_phase[v] == P_ATT) begin
      if (m_a[v] == 0 || m_lv[v] + m_a[v] >= MAXV) begin m_lv[v] = MAXV; m_phase[v] = P_DEC; end
      else m_lv[v] = m_lv[v] + m_a[v];
    end else if (m_phase[v] == P_DEC) begin
      if (m_d[v] == 0 || m_lv[v] <= m_s[v] || m_lv[v] - m_d[v] <= m_s[v]) begin
        m_lv[v] = m_s[v]; m_phase[v] = P_SUS;
      end else m_lv[v] = m_lv[v] - m_d[v];
    end else begin
      m_lv[v] = m_s[v];
    end
  endfunction

  function automatic logic [NV-1:0] model_idle();
    logic [NV-1:0] m;
    for (int v = 0; v < NV; v++) m[v] = (m_phase[v] == P_IDLE);
    return m;
  endfunction

  task automatic cfg_write(input int v, input logic [2:0] sel, input logic [31:0] data);
    cfg_we = 1'b1; cfg_voice = 2'(v); cfg_sel = sel; cfg_data = data;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    model_cfg(v, sel, data);
  endtask

  // Starts a sweep at the current cycle; optional write during slot wr_voice
  // and optional extra tick in relative cycle extra_c (0 = none)
  task automatic run_sweep(input int wr_voice, input logic [2:0] wr_sel,
                           input logic [31:0] wr_data, input int extra_c);
    longint exp_lv [NV];
    for (int v = 0; v < NV; v++) begin
      model_step(v, gate[v]);
      exp_lv[v] = m_lv[v];
    end
    tick = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= NV + 1; c++) begin
      tick      = (c == extra_c);
      cfg_we    = (wr_voice >= 0) && (c == wr_voice + 1);
      cfg_voice = 2'(wr_voice);
      cfg_sel   = wr_sel;
      cfg_data  = wr_data;
      @(negedge clk);
      check("busy", 64'(busy), 64'(c <= NV));
      check("overrun", 64'(overrun), 64'(c == extra_c));
      check("env_valid", 64'(env_valid), 64'(c >= 2));
      if (c >= 2) begin
        check("env_voice", 64'(env_voice), 64'(c - 2));
        check("env_out", 64'(env_out), exp_lv[c-2]);
      end
      @(posedge clk); #1;
    end
    tick = 1'b0; cfg_we = 1'b0;
    if (wr_voice >= 0) model_cfg(wr_voice, wr_sel, wr_data);
    check("idle_mask", 64'(idle_mask), 64'(model_idle()));
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 3))
      0: return 32'd0;
      1: return 32'd1 << $urandom_range(24, 31);
      2: return $urandom;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_env_out", 64'(env_out), 64'd0);
    check("rst_env_voice", 64'(env_voice), 64'd0);
    check("rst_env_valid", 64'(env_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_idle_mask", 64'(idle_mask), 64'hF);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    repeat (3) run_sweep(-1, 3'd0, 32'd0, 0);

    cfg_write(0, 3'd0, 32'h4000_0000);
    cfg_write(0, 3'd1, 32'h1000_0000);
    cfg_write(0, 3'd2, 32'h8000_0000);
    cfg_write(0, 3'd3, 32'h2000_0000);
    gate[0] = 1'b1;
    repeat (14) run_sweep(-1, 3'd0, 32'd0, 0);
    check("v0_sustain_lv", 64'(m_lv[0]), 64'h8000_0000);
    gate[0] = 1'b0;
    repeat (6) run_sweep(-1, 3'd0, 32'd0, 0);

    gate[1] = 1'b1;
    repeat (2) run_sweep(-1, 3'd0, 32'd0, 0);
    gate[1] = 1'b0;
    run_sweep(-1, 3'd0, 32'd0, 0);

    for (int v = 2; v < 4; v++) begin
      cfg_write(v, 3'd0, 32'h4000_0000);
      cfg_write(v, 3'd3, 32'h1000_0000);
    end
    cfg_write(3, 3'd4, 32'd1);
    gate[3:2] = 2'b11;
    run_sweep(-1, 3'd0, 32'd0, 0);
    gate[3:2] = 2'b00;
    run_sweep(-1, 3'd0, 32'd0, 0);
    gate[3:2] = 2'b11;
    repeat (2) run_sweep(-1, 3'd0, 32'd0, 0);

    run_sweep(-1, 3'd0, 32'd0, 2);

    cfg_write(1, 3'd2, 32'h1234_5678);
    gate[1] = 1'b1;
    repeat (2) run_sweep(-1, 3'd0, 32'd0, 0);
    run_sweep(1, 3'd2, 32'h0BAD_F00D, 0);
    run_sweep(-1, 3'd0, 32'd0, 0);
    cfg_write(1, 3'd5, 32'h7777_7777);
    run_sweep(-1, 3'd0, 32'd0, 0);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 0) gate = NV'($urandom);
      if ($urandom_range(0, 2) == 0)
        cfg_write($urandom_range(0, NV - 1), 3'($urandom_range(0, 7)), rand_val());
      if ($urandom_range(0, 3) == 0)
        run_sweep($urandom_range(0, NV - 1), 3'($urandom_range(0, 7)), rand_val(), 0);
      else
        run_sweep(-1, 3'd0, 32'd0, ($urandom_range(0, 4) == 0) ? $urandom_range(1, NV) : 0);
    end

    gate = '1;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_valid", 64'(env_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_env_out", 64'(env_out), 64'd0);
    check("arst_env_voice", 64'(env_voice), 64'd0);
    check("arst_env_valid", 64'(env_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_idle_mask", 64'(idle_mask), 64'hF);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    gate = '0;
    @(posedge clk); #1;
    run_sweep(-1, 3'd0, 32'd0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
